// File: rtl/ysyx_22050518_div_pkg.sv
// Shared constants, state encoding and helpers for the iterative RV64M divider.
package ysyx_22050518_div_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned W32   = 32;
    localparam int unsigned W64   = 64;
    localparam int unsigned CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
    localparam logic [31:0]     INT_MIN32  = 32'h8000_0000;
    localparam logic [63:0]     INT_MIN64  = 64'h8000_0000_0000_0000;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22050518_div_if.sv
// Request/response bundle between the EXU issue logic and the divider.
interface ysyx_22050518_div_if;
    import ysyx_22050518_div_pkg::*;

    logic            div_valid;
    logic            flush;
    logic            divw;
    logic            div_signed;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            div_ready;
    logic            out_valid;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;

    modport master (
        output div_valid, flush, divw, div_signed, dividend, divisor,
        input  div_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  div_valid, flush, divw, div_signed, dividend, divisor,
        output div_ready, out_valid, quotient, remainder
    );

endinterface

// File: rtl/ysyx_22050518_div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract divisor.
module ysyx_22050518_div_step
    import ysyx_22050518_div_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic [XLEN-1:0] next_quo
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    logic          borrow;

    always_comb begin
        shifted  = {rem, quo[XLEN-1]};
        trial    = shifted - {1'b0, divisor};
        borrow   = trial[XLEN];
        next_rem = borrow ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        next_quo = {quo[XLEN-2:0], ~borrow};
    end

endmodule

// File: rtl/ysyx_22050518_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU and W forms.
// DIV_FAST_SPECIAL_EN: divide-by-zero / signed overflow bypass CALC and finish in one cycle.
module ysyx_22050518_div
    import ysyx_22050518_div_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    ysyx_22050518_div_if.slave  bus
);

    state_t           state, next_state;
    logic [CNT_W-1:0] counter;
    logic [XLEN-1:0]  rem_q, quo_q, div_abs;
    logic             neg_q, neg_r, w_op, zero_q, ovf_q;
    logic [XLEN-1:0]  q_out, r_out;

    logic             accept;
    logic             a_sign, b_sign, is_zero, is_ovf;
    logic [31:0]      a_lo, b_lo;
    logic [XLEN-1:0]  a_abs, b_abs;
    logic [XLEN-1:0]  nrem, nquo, fin_q, fin_r;
    logic [31:0]      q32, r32;
    logic [XLEN-1:0]  q64, r64;

    assign accept = bus.div_valid && bus.div_ready && !bus.flush;

    always_comb begin
        a_lo   = bus.dividend[31:0];
        b_lo   = bus.divisor[31:0];
        a_sign = bus.div_signed & (bus.divw ? a_lo[31] : bus.dividend[XLEN-1]);
        b_sign = bus.div_signed & (bus.divw ? b_lo[31] : bus.divisor[XLEN-1]);
        if (bus.divw) begin
            a_abs   = {32'b0, a_sign ? -a_lo : a_lo};
            b_abs   = {32'b0, b_sign ? -b_lo : b_lo};
            is_zero = (b_lo == '0);
            is_ovf  = bus.div_signed && (a_lo == INT_MIN32) && (b_lo == '1);
        end else begin
            a_abs   = a_sign ? -bus.dividend : bus.dividend;
            b_abs   = b_sign ? -bus.divisor : bus.divisor;
            is_zero = (bus.divisor == '0);
            is_ovf  = bus.div_signed && (bus.dividend == INT_MIN64) && (bus.divisor == '1);
        end
    end

`ifdef DIV_FAST_SPECIAL_EN
    logic            is_special;
    logic [XLEN-1:0] spec_q, spec_r;

    always_comb begin
        is_special = is_zero | is_ovf;
        if (is_zero) begin
            spec_q = DIV_ZERO_Q;
            spec_r = bus.divw ? sext32(a_lo) : bus.dividend;
        end else begin
            spec_q = bus.divw ? sext32(INT_MIN32) : INT_MIN64;
            spec_r = '0;
        end
    end
`endif

    ysyx_22050518_div_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (div_abs),
        .next_rem (nrem),
        .next_quo (nquo)
    );

    // Divide-by-zero remainder falls out of the datapath (rem accumulates |dividend|).
    always_comb begin
        q32   = neg_q ? -nquo[31:0] : nquo[31:0];
        r32   = neg_r ? -nrem[31:0] : nrem[31:0];
        q64   = neg_q ? -nquo : nquo;
        r64   = neg_r ? -nrem : nrem;
        fin_q = w_op ? sext32(q32) : q64;
        fin_r = w_op ? sext32(r32) : r64;
        if (zero_q) begin
            fin_q = DIV_ZERO_Q;
        end else if (ovf_q) begin
            fin_q = w_op ? sext32(INT_MIN32) : INT_MIN64;
            fin_r = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) begin
`ifdef DIV_FAST_SPECIAL_EN
                next_state = is_special ? DONE : CALC;
`else
                next_state = CALC;
`endif
            end
            CALC: if (counter == CNT_W'(1)) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (bus.flush) next_state = IDLE;
    end

    always_comb begin
        bus.div_ready = (state == IDLE);
        bus.out_valid = (state == DONE) && !bus.flush;
        bus.quotient  = q_out;
        bus.remainder = r_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_abs <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            w_op    <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            q_out   <= '0;
            r_out   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rem_q   <= '0;
                    // W ops sit in the top half so the shift feeds bit 31 into rem first
                    quo_q   <= bus.divw ? {a_abs[31:0], 32'b0} : a_abs;
                    div_abs <= b_abs;
                    neg_q   <= a_sign ^ b_sign;
                    neg_r   <= a_sign;
                    w_op    <= bus.divw;
                    zero_q  <= is_zero;
                    ovf_q   <= is_ovf;
                    counter <= bus.divw ? CNT_W'(W32) : CNT_W'(W64);
`ifdef DIV_FAST_SPECIAL_EN
                    if (is_special) begin
                        q_out <= spec_q;
                        r_out <= spec_r;
                    end
`endif
                end
                CALC: begin
                    if (bus.flush) begin
                        counter <= '0;
                    end else begin
                        rem_q   <= nrem;
                        quo_q   <= nquo;
                        counter <= counter - CNT_W'(1);
                        if (counter == CNT_W'(1)) begin
                            q_out <= fin_q;
                            r_out <= fin_r;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050518_div.sv
// Directed self-checking bench for ysyx_22050518_div (inputs driven at negedge/after posedge, sampled at negedge).
module tb_ysyx_22050518_div;
    import ysyx_22050518_div_pkg::*;

`ifdef DIV_FAST_SPECIAL_EN
    localparam int LAT_SP64 = 1;
    localparam int LAT_SP32 = 1;
`else
    localparam int LAT_SP64 = 65;
    localparam int LAT_SP32 = 33;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   passed = 0;
    int   total  = 0;

    ysyx_22050518_div_if bus ();

    ysyx_22050518_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Call at a negedge; returns at posedge+1 after the accept edge with operands scrambled.
    task automatic start_op(input string tag, input logic w, input logic s,
                            input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        bus.div_valid  = 1'b1;
        bus.divw       = w;
        bus.div_signed = s;
        bus.dividend   = a;
        bus.divisor    = b;
        while (bus.div_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_acc_timeout"}, 64'(n >= 200), 64'(0));
        @(posedge clk);
        #1;
        bus.div_valid = 1'b0;
        bus.dividend  = {$urandom, $urandom};
        bus.divisor   = {$urandom, $urandom};
        bus.divw      = 1'($urandom);
        bus.div_signed = 1'($urandom);
    endtask

    // Ends at the negedge where out_valid is seen high.
    task automatic wait_result(input string tag, input logic [63:0] eq,
                               input logic [63:0] er, input int lat);
        int n = 0;
        int rdy = 0;
        bit seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.div_ready) rdy++;
            if (bus.out_valid) seen = 1'b1;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_busy_ready"}, 64'(rdy), 64'(0));
        chk({tag, "_q"}, bus.quotient, eq);
        chk({tag, "_r"}, bus.remainder, er);
    endtask

    initial begin
        int pulses;
        logic [63:0] hold_q, hold_r;

        bus.div_valid  = 1'b0;
        bus.flush      = 1'b0;
        bus.divw       = 1'b0;
        bus.div_signed = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.div_ready), 64'(1));
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_q", bus.quotient, 64'(0));
        chk("rst_r", bus.remainder, 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        start_op("divu_100_7", 1'b0, 1'b0, 64'd100, 64'd7);
        wait_result("divu_100_7", 64'd14, 64'd2, 65);
        @(negedge clk);
        chk("pulse_once", 64'(bus.out_valid), 64'(0));
        chk("ready_after", 64'(bus.div_ready), 64'(1));

        // Consecutive calls below are accepted the cycle div_ready returns.
        start_op("div_m7_2", 1'b0, 1'b1, -64'sd7, 64'd2);
        wait_result("div_m7_2", 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        start_op("divw_ovf", 1'b1, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_result("divw_ovf", 64'hFFFF_FFFF_8000_0000, 64'd0, LAT_SP32);
        start_op("divu_zero", 1'b0, 1'b0, 64'h1234, 64'd0);
        wait_result("divu_zero", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, LAT_SP64);
        start_op("div_ovf", 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_result("div_ovf", 64'h8000_0000_0000_0000, 64'd0, LAT_SP64);
        start_op("divuw_sext", 1'b1, 1'b0, 64'h5555_0000_FFFF_FFF0, 64'hAAAA_0000_0000_0001);
        wait_result("divuw_sext", 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 33);
        start_op("divw_m7_2", 1'b1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'h0000_0000_0000_0002);
        wait_result("divw_m7_2", 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        start_op("divw_zero", 1'b1, 1'b1, 64'hABCD_0000_8000_0001, 64'hFFFF_FFFF_0000_0000);
        wait_result("divw_zero", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, LAT_SP32);
        start_op("divu_max", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10);
        wait_result("divu_max", 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 65);
        start_op("div_7_m2", 1'b0, 1'b1, 64'd7, -64'sd2);
        wait_result("div_7_m2", 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);

        // Flush in the 20th CALC cycle: no pulse, results untouched.
        @(negedge clk);
        start_op("flush_calc", 1'b0, 1'b0, 64'd50, 64'd5);
        repeat (20) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_ready", 64'(bus.div_ready), 64'(1));
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        chk("flush_no_pulse", 64'(pulses), 64'(0));
        chk("flush_hold_q", bus.quotient, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("flush_hold_r", bus.remainder, 64'd1);
        start_op("after_flush", 1'b0, 1'b0, 64'd9, 64'd3);
        wait_result("after_flush", 64'd3, 64'd0, 65);

        // Flush while in DONE suppresses out_valid combinationally.
        @(negedge clk);
        start_op("flush_done", 1'b0, 1'b0, 64'd1000, 64'd10);
        repeat (65) @(negedge clk);
        chk("fdone_pre", 64'(bus.out_valid), 64'(1));
        bus.flush = 1'b1;
        #1;
        chk("fdone_suppressed", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        bus.flush = 1'b0;
        chk("fdone_ready", 64'(bus.div_ready), 64'(1));

        // Flush together with div_valid in IDLE: nothing accepted.
        bus.div_valid = 1'b1;
        bus.flush     = 1'b1;
        bus.divw      = 1'b0;
        bus.dividend  = 64'd5;
        bus.divisor   = 64'd1;
        @(posedge clk);
        #1;
        bus.div_valid = 1'b0;
        bus.flush     = 1'b0;
        chk("fv_not_accepted", 64'(bus.div_ready), 64'(1));
        pulses = 0;
        repeat (70) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        chk("fv_no_pulse", 64'(pulses), 64'(0));

        // Asynchronous reset mid-CALC.
        start_op("rst_mid", 1'b0, 1'b0, 64'd100, 64'd7);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(bus.div_ready), 64'(1));
        chk("arst_valid", 64'(bus.out_valid), 64'(0));
        chk("arst_q", bus.quotient, 64'd0);
        chk("arst_r", bus.remainder, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Results hold while operand inputs wander.
        start_op("stable", 1'b0, 1'b0, 64'hFFFF_0000, 64'h100);
        wait_result("stable", 64'h00FF_FF00, 64'd0, 65);
        hold_q = 64'h00FF_FF00;
        hold_r = 64'd0;
        repeat (6) begin
            @(negedge clk);
            bus.dividend   = {$urandom, $urandom};
            bus.divisor    = {$urandom, $urandom};
            bus.div_signed = 1'($urandom);
        end
        chk("stable_q", bus.quotient, hold_q);
        chk("stable_r", bus.remainder, hold_r);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
